// File: rtl/spi_tx_pkg.sv
// rtl/spi_tx_pkg.sv - shared types and helpers for the SPI slave transmitter
package spi_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    localparam int SYNC_STAGES = 2;

    function automatic int frame_len(input int width, input bit parity_en);
        return parity_en ? width + 1 : width;
    endfunction

endpackage

// File: rtl/spi_input_sync.sv
// rtl/spi_input_sync.sv - multi-flop synchroniser with rise/fall strobes for an asynchronous pin
module spi_input_sync
    import spi_tx_pkg::*;
#(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Reset to the pin's idle level so leaving reset never fakes an edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RESET_VALUE}};
            prev_q <= RESET_VALUE;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_tx.sv
// rtl/spi_slave_tx.sv - SPI mode-0 slave transmitter; SPI_TX_PARITY_EN appends an even-parity bit
module spi_slave_tx
    import spi_tx_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] IDLE_WORD = {WIDTH{1'b0}}
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    input  logic             spi_clock_in,
    input  logic             spi_cs_in,
    output logic             spi_data_out,
    output logic             sent,
    output logic             underrun,
    output logic             aborted
);

`ifdef SPI_TX_PARITY_EN
    localparam int FRAME_LEN = frame_len(WIDTH, 1'b1);

    function automatic logic [FRAME_LEN-1:0] frame_word(input logic [WIDTH-1:0] word);
        return {word, ^word};
    endfunction
`else
    localparam int FRAME_LEN = frame_len(WIDTH, 1'b0);

    function automatic logic [FRAME_LEN-1:0] frame_word(input logic [WIDTH-1:0] word);
        return word;
    endfunction
`endif

    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    spi_input_sync #(.RESET_VALUE(1'b0)) u_sclk_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (spi_clock_in),
        .rise     (sclk_rise),
        .fall     (sclk_fall)
    );

    spi_input_sync #(.RESET_VALUE(1'b1)) u_cs_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (spi_cs_in),
        .rise     (cs_rise),
        .fall     (cs_fall)
    );

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     holding_q;
    logic                 holding_valid_q;
    logic [FRAME_LEN-1:0] shift_q;
    logic [CNT_W-1:0]     bit_count_q;
    logic                 sent_q, underrun_q, aborted_q;
    logic                 sent_d, underrun_d, aborted_d;
    logic                 start_frame;

    always_comb begin
        state_d     = state_q;
        start_frame = 1'b0;
        sent_d      = 1'b0;
        underrun_d  = 1'b0;
        aborted_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d     = ST_SHIFT;
                    start_frame = 1'b1;
                    underrun_d  = !holding_valid_q && !load;
                end
            end
            ST_SHIFT: begin
                // A CS release wins over a coincident final sample edge.
                if (cs_rise) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else if (sclk_rise && bit_count_q == CNT_W'(FRAME_LEN - 1)) begin
                    state_d = ST_DONE;
                    sent_d  = 1'b1;
                end
            end
            ST_DONE: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            holding_q       <= '0;
            holding_valid_q <= 1'b0;
            shift_q         <= '0;
            bit_count_q     <= '0;
            sent_q          <= 1'b0;
            underrun_q      <= 1'b0;
            aborted_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            sent_q     <= sent_d;
            underrun_q <= underrun_d;
            aborted_q  <= aborted_d;
            if (start_frame) begin
                bit_count_q <= '0;
                if (holding_valid_q) begin
                    shift_q         <= frame_word(holding_q);
                    holding_valid_q <= 1'b0;
                end else if (load) begin
                    shift_q <= frame_word(data_in);
                end else begin
                    shift_q <= frame_word(IDLE_WORD);
                end
            end else begin
                if (load && !holding_valid_q) begin
                    holding_q       <= data_in;
                    holding_valid_q <= 1'b1;
                end
                if (state_q == ST_SHIFT && sclk_fall) begin
                    shift_q <= {shift_q[FRAME_LEN-2:0], 1'b0};
                end
                if (state_q == ST_SHIFT && sclk_rise) begin
                    bit_count_q <= bit_count_q + CNT_W'(1);
                end
            end
        end
    end

    assign ready        = !holding_valid_q;
    assign spi_data_out = (state_q == ST_SHIFT) ? shift_q[FRAME_LEN-1] : 1'b0;
    assign sent         = sent_q;
    assign underrun     = underrun_q;
    assign aborted      = aborted_q;

endmodule
